design_switch_sequencer: RTL and testbench

- Parametrised next-generation design multiplexer for the shared user project area.
- Selects one of NUM_DESIGNS team designs and routes that design's gpio_out/gpio_oeb to the pads.
- design_select is glitch-filtered before it takes effect.
- Every design change follows a safe sequence: pads tri-stated, all designs held in reset for RST_HOLD cycles, then only the new design is released.
- Sits between the top-level select/GPIO pins and the per-design wrappers; its reset and chip-select outputs drive each wrapper directly.

---
 rtl/design_switch_sequencer_if.sv | 29 ++
 rtl/design_switch_sequencer.sv | 159 +++++++++++++++
 tb/tb_design_switch_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/design_switch_sequencer_if.sv
// Bundle of select/GPIO signals between the top-level pads, the per-design
// wrappers and design_switch_sequencer.
interface design_switch_sequencer_if #(
  parameter int NUM_DESIGNS = 12,
  parameter int GPIO_W      = 34,
  parameter int SEL_W       = 4
);
  logic [SEL_W-1:0]              design_select;
  logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_out;
  logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_oeb;
  logic [GPIO_W-1:0]             gpio_out;
  logic [GPIO_W-1:0]             gpio_oeb;
  logic [NUM_DESIGNS-1:0]        designs_ncs;
  logic [NUM_DESIGNS-1:0]        designs_n_rst;
  logic [SEL_W-1:0]              active_design;
  logic                          busy;

  // Sequencer side
  modport slave (
    input  design_select, designs_gpio_out, designs_gpio_oeb,
    output gpio_out, gpio_oeb, designs_ncs, designs_n_rst, active_design, busy
  );

  // Pad / wrapper side
  modport master (
    output design_select, designs_gpio_out, designs_gpio_oeb,
    input  gpio_out, gpio_oeb, designs_ncs, designs_n_rst, active_design, busy
  );
endinterface

// File: rtl/design_switch_sequencer.sv
// design_switch_sequencer: glitch-filtered design selector for the shared
// user area. Every change tri-states the pads, holds all designs in reset for
// RST_HOLD cycles, then releases only the new design and routes its GPIOs.
// Optional macro DESIGN_SEL_LOCK_EN: latch the first design that reaches RUN
// until rst.
module design_switch_sequencer #(
  parameter int NUM_DESIGNS = 12,
  parameter int GPIO_W      = 34,
  parameter int SEL_W       = 4,
  parameter int SEL_STABLE  = 4,
  parameter int RST_HOLD    = 16
) (
  input logic clk,
  input logic rst,
  design_switch_sequencer_if.slave bus
);
  localparam int CW = $clog2(SEL_STABLE + 1);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SEL_STABLE);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {IDLE, SWITCH, RUN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SEL_W-1:0]       r_target, w_target_nxt;
  logic [HW-1:0]          r_hold, w_hold_nxt;
  logic [SEL_W-1:0]       r_cand, w_cand_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0]       w_san;
  logic                   w_accept;

  logic [GPIO_W-1:0]      r_gout, w_gout_nxt;
  logic [GPIO_W-1:0]      r_goeb, w_goeb_nxt;
  logic [NUM_DESIGNS-1:0] r_ncs, w_ncs_nxt;
  logic [NUM_DESIGNS-1:0] r_nrst, w_nrst_nxt;
  logic [SEL_W-1:0]       r_act, w_act_nxt;
  logic                   r_busy, w_busy_nxt;

`ifdef DESIGN_SEL_LOCK_EN
  logic r_lock;
`endif

  // Sanitise the raw select and run the stability filter
  always_comb begin
    w_san = '0;
    if (bus.design_select != '0 && bus.design_select <= SEL_W'(NUM_DESIGNS))
      w_san = bus.design_select;
    if (w_san != r_cand) begin
      w_cand_nxt = w_san;
      w_cnt_nxt  = CW'(1);
    end else begin
      w_cand_nxt = r_cand;
      w_cnt_nxt  = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
    end
    // target always tracks an accepted candidate, so a saturated candidate
    // equal to target never re-triggers a switch
    w_accept = (w_cnt_nxt == CNT_MAX) && (w_cand_nxt != r_target);
`ifdef DESIGN_SEL_LOCK_EN
    if (r_lock) w_accept = 1'b0;
`endif
  end

  // Next state plus next value of every registered output
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_hold_nxt   = r_hold;
    case (r_state)
      IDLE: w_target_nxt = '0;
      SWITCH: begin
        w_hold_nxt = r_hold + 1'b1;
        if (r_hold == HOLD_LAST) begin
          w_hold_nxt  = '0;
          w_state_nxt = (r_target != '0) ? RUN : IDLE;
        end
      end
      RUN: ;
      default: begin
        w_state_nxt  = IDLE;
        w_target_nxt = '0;
        w_hold_nxt   = '0;
      end
    endcase
    // a new accepted value always (re)starts the full reset hold
    if (w_accept) begin
      w_target_nxt = w_cand_nxt;
      w_state_nxt  = SWITCH;
      w_hold_nxt   = '0;
    end

    w_ncs_nxt  = '1;
    w_nrst_nxt = '0;
    w_act_nxt  = '0;
    w_busy_nxt = (w_state_nxt == SWITCH);
    w_gout_nxt = '0;
    w_goeb_nxt = '1;
    if (w_state_nxt == RUN) begin
      w_act_nxt = w_target_nxt;
      for (int k = 0; k < NUM_DESIGNS; k++)
        if (w_target_nxt == SEL_W'(k + 1)) begin
          w_ncs_nxt[k]  = 1'b0;
          w_nrst_nxt[k] = 1'b1;
        end
    end
    // pads follow a design only once it was already released last cycle and
    // stays released this cycle; leaving RUN tri-states on the same edge
    if (r_state == RUN && w_state_nxt == RUN) begin
      for (int k = 0; k < NUM_DESIGNS; k++)
        if (r_target == SEL_W'(k + 1)) begin
          w_gout_nxt = bus.designs_gpio_out[k*GPIO_W +: GPIO_W];
          w_goeb_nxt = bus.designs_gpio_oeb[k*GPIO_W +: GPIO_W];
        end
    end
  end

  // State, filter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_hold   <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_gout   <= '0;
      r_goeb   <= '1;
      r_ncs    <= '1;
      r_nrst   <= '0;
      r_act    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_hold   <= w_hold_nxt;
      r_cand   <= w_cand_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gout   <= w_gout_nxt;
      r_goeb   <= w_goeb_nxt;
      r_ncs    <= w_ncs_nxt;
      r_nrst   <= w_nrst_nxt;
      r_act    <= w_act_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

`ifdef DESIGN_SEL_LOCK_EN
  // One-shot lock set on the first entry into RUN
  always_ff @(posedge clk) begin
    if (rst) r_lock <= 1'b0;
    else if (w_state_nxt == RUN) r_lock <= 1'b1;
  end
`endif

  assign bus.gpio_out      = r_gout;
  assign bus.gpio_oeb      = r_goeb;
  assign bus.designs_ncs   = r_ncs;
  assign bus.designs_n_rst = r_nrst;
  assign bus.active_design = r_act;
  assign bus.busy          = r_busy;
endmodule

// File: tb/tb_design_switch_sequencer.sv
// Bench for design_switch_sequencer: table of select steps with a scoreboard
// of expected steady-state outputs, plus hand-written timing sequences.
module tb_design_switch_sequencer;
  localparam int NUM = 12, GW = 34, SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  design_switch_sequencer_if #(.NUM_DESIGNS(NUM), .GPIO_W(GW), .SEL_W(SW)) bus ();

  design_switch_sequencer #(
    .NUM_DESIGNS(NUM), .GPIO_W(GW), .SEL_W(SW), .SEL_STABLE(4), .RST_HOLD(16)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0, n_err = 0, inv_err = 0;

  logic [GW-1:0] s_out [1:NUM];
  logic [GW-1:0] s_oeb [1:NUM];

  typedef struct {
    logic [SW-1:0]  sel;
    int             cyc;
    logic [NUM-1:0] nrst;
    logic [NUM-1:0] ncs;
    logic [SW-1:0]  act;
  } vec_t;

  typedef struct {
    logic [NUM-1:0] nrst;
    logic [NUM-1:0] ncs;
    logic [SW-1:0]  act;
    logic           busy;
    logic [GW-1:0]  gout;
    logic [GW-1:0]  goeb;
  } exp_t;

  vec_t tbl [9];
  exp_t sbq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_slices();
    for (int k = 1; k <= NUM; k++) begin
      bus.designs_gpio_out[(k-1)*GW +: GW] = s_out[k];
      bus.designs_gpio_oeb[(k-1)*GW +: GW] = s_oeb[k];
    end
  endtask

  task automatic check_exp(input string tag, input exp_t e);
    chk({tag, "_nrst"}, 64'(bus.designs_n_rst), 64'(e.nrst));
    chk({tag, "_ncs"},  64'(bus.designs_ncs),   64'(e.ncs));
    chk({tag, "_act"},  64'(bus.active_design), 64'(e.act));
    chk({tag, "_busy"}, 64'(bus.busy),          64'(e.busy));
    chk({tag, "_gout"}, 64'(bus.gpio_out),      64'(e.gout));
    chk({tag, "_goeb"}, 64'(bus.gpio_oeb),      64'(e.goeb));
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.nrst = '0; e.ncs = '1; e.act = '0; e.busy = 1'b0;
    e.gout = '0; e.goeb = '1;
    return e;
  endfunction

  // Pad-side safety: one released design at most, pads enabled only then
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(bus.designs_n_rst) > 1) inv_err++;
      if (bus.gpio_oeb != '1 && bus.designs_n_rst == '0) inv_err++;
    end
  end

  initial begin
    int first_busy, nbusy, first_run, saw7, gap;
    logic [NUM-1:0] run_val;
    exp_t e;

    for (int k = 1; k <= NUM; k++) begin
      s_out[k] = {2'(k), 32'(k * 32'h0101_0101) ^ 32'h5A00_00A5};
      s_oeb[k] = ~(GW'(3) << k);
    end
    s_out[4] = 34'h2_AAAA_5555;
    load_slices();
    bus.design_select = '0;

    tbl[0] = '{sel: 4'd0,  cyc: 20, nrst: 12'h000, ncs: 12'hFFF, act: 4'd0};
    tbl[1] = '{sel: 4'd4,  cyc: 25, nrst: 12'h008, ncs: 12'hFF7, act: 4'd4};
    tbl[2] = '{sel: 4'd4,  cyc: 5,  nrst: 12'h008, ncs: 12'hFF7, act: 4'd4};
    tbl[3] = '{sel: 4'd2,  cyc: 25, nrst: 12'h002, ncs: 12'hFFD, act: 4'd2};
    tbl[4] = '{sel: 4'd13, cyc: 25, nrst: 12'h000, ncs: 12'hFFF, act: 4'd0};
    tbl[5] = '{sel: 4'd12, cyc: 25, nrst: 12'h800, ncs: 12'h7FF, act: 4'd12};
    tbl[6] = '{sel: 4'd15, cyc: 25, nrst: 12'h000, ncs: 12'hFFF, act: 4'd0};
    tbl[7] = '{sel: 4'd1,  cyc: 25, nrst: 12'h001, ncs: 12'hFFE, act: 4'd1};
    tbl[8] = '{sel: 4'd0,  cyc: 25, nrst: 12'h000, ncs: 12'hFFF, act: 4'd0};

    // reset state
    rst = 1'b1;
    tick(2);
    check_exp("reset", idle_exp());
    rst = 1'b0;

`ifdef DESIGN_SEL_LOCK_EN
    bus.design_select = 4'd4;
    tick(25);
    chk("lock_run4", 64'(bus.designs_n_rst), 64'h008);
    bus.design_select = 4'd9;
    tick(30);
    chk("lock_hold_nrst", 64'(bus.designs_n_rst), 64'h008);
    chk("lock_hold_act",  64'(bus.active_design), 64'd4);
    chk("lock_hold_busy", 64'(bus.busy), 64'd0);
    rst = 1'b1;
    tick(1);
    check_exp("lock_rst", idle_exp());
    rst = 1'b0;
    tick(25);
    chk("lock_after_rst", 64'(bus.designs_n_rst), 64'h100);
`else
    // table steps through scoreboard
    for (int i = 0; i < 9; i++) begin
      bus.design_select = tbl[i].sel;
      e.nrst = tbl[i].nrst;
      e.ncs  = tbl[i].ncs;
      e.act  = tbl[i].act;
      e.busy = 1'b0;
      e.gout = (tbl[i].act == 0) ? '0 : s_out[tbl[i].act];
      e.goeb = (tbl[i].act == 0) ? '1 : s_oeb[tbl[i].act];
      sbq.push_back(e);
      tick(tbl[i].cyc);
      e = sbq.pop_front();
      check_exp($sformatf("tbl%0d", i), e);
    end

    // acceptance latency, busy length, gpio first-valid edge
    bus.design_select = 4'd4;
    first_busy = -1; nbusy = 0; first_run = -1;
    for (int t = 1; t <= 40; t++) begin
      tick(1);
      if (bus.busy) begin
        nbusy++;
        if (first_busy < 0) first_busy = t;
      end
      if (bus.designs_n_rst != '0 && first_run < 0) first_run = t;
      if (t == 20) begin
        chk("lat_gout_t20", 64'(bus.gpio_out), 64'h0);
        chk("lat_goeb_t20", 64'(bus.gpio_oeb), 64'(34'h3_FFFF_FFFF));
      end
      if (t == 21) begin
        chk("lat_gout_t21", 64'(bus.gpio_out), 64'(34'h2_AAAA_5555));
        chk("lat_goeb_t21", 64'(bus.gpio_oeb), 64'(s_oeb[4]));
      end
    end
    chk("lat_first_busy", 64'(first_busy), 64'd4);
    chk("lat_busy_len",   64'(nbusy),      64'd16);
    chk("lat_first_run",  64'(first_run),  64'd20);
    chk("lat_ncs",        64'(bus.designs_ncs), 64'hFF7);
    chk("lat_act",        64'(bus.active_design), 64'd4);

    // live slice change shows up one edge later
    s_out[4] = 34'h1_2345_6789;
    load_slices();
    tick(1);
    chk("live_gout", 64'(bus.gpio_out), 64'h1_2345_6789);

    // glitch shorter than the filter window
    bus.design_select = 4'd7;
    tick(3);
    bus.design_select = 4'd4;
    for (int t = 1; t <= 25; t++) begin
      tick(1);
      chk($sformatf("glitch_nrst_%0d", t), 64'(bus.designs_n_rst), 64'h008);
      chk($sformatf("glitch_busy_%0d", t), 64'(bus.busy), 64'd0);
    end

    // new selection mid-switch restarts the full hold
    bus.design_select = 4'd7;
    tick(4);
    chk("restart_acc7", 64'(bus.busy), 64'd1);
    tick(8);
    bus.design_select = 4'd2;
    first_run = -1; saw7 = 0; gap = 0; run_val = '0;
    for (int t = 1; t <= 30; t++) begin
      tick(1);
      if (bus.designs_n_rst[6]) saw7 = 1;
      if (bus.designs_n_rst != '0 && first_run < 0) begin
        first_run = t;
        run_val   = bus.designs_n_rst;
      end
      if (t < 20 && !bus.busy) gap++;
    end
    chk("restart_first_run", 64'(first_run), 64'd20);
    chk("restart_run_val",   64'(run_val),   64'h002);
    chk("restart_saw7",      64'(saw7),      64'd0);
    chk("restart_busy_gap",  64'(gap),       64'd0);

    // rst in the middle of a switch
    bus.design_select = 4'd5;
    tick(8);
    chk("rst_sw_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    bus.design_select = 4'd0;
    tick(1);
    check_exp("rst_sw", idle_exp());
    rst = 1'b0;
    tick(5);
    check_exp("rst_sw_idle", idle_exp());

    // rst while running
    bus.design_select = 4'd3;
    tick(25);
    chk("rst_run_pre", 64'(bus.designs_n_rst), 64'h004);
    rst = 1'b1;
    tick(1);
    check_exp("rst_run", idle_exp());
    rst = 1'b0;
    bus.design_select = 4'd0;
    tick(3);
`endif

    chk("invariant", 64'(inv_err), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
